perf_counter_unit: RTL and testbench

- Sits directly downstream of the processor hierarchy and consumes the same per-cycle retire and cache signals the simulation bench monitors.
- Accumulates synthesizable performance counters: cycles, retired instructions, and I/D cache requests and hits.
- Freezes the counters when the processor halts.
- Exposes an atomic snapshot readout over a 4-phase req/ack handshake, so counts can be read from hardware instead of only from the bench.

---
 rtl/perf_counter_unit.sv | 168 ++++++++++++++++
 tb/tb_perf_counter_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_unit.sv
// perf_counter_unit: performance counters for cycles, retired instructions and
// I/D cache requests and hits. The counters freeze on halt and saturate at
// all-ones with sticky overflow flags. An atomic snapshot is read out over a
// 4-phase rd_req/rd_ack handshake.
// Optional build macro PERF_STALL_CNT_EN adds a stall input, a stall-cycle
// counter (index 6) readable on rd_sel 7, and a seventh ovf bit.
module perf_counter_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cnt_en,
  input  logic             halt,
  input  logic             reg_wrt,
  input  logic             mem_wrt,
  input  logic             dc_req,
  input  logic             dc_hit,
  input  logic             ic_req,
  input  logic             ic_hit,
  input  logic             clr,
  input  logic             rd_req,
  input  logic [2:0]       rd_sel,
`ifdef PERF_STALL_CNT_EN
  input  logic             stall,
  output logic [6:0]       ovf,
`else
  output logic [5:0]       ovf,
`endif
  output logic             rd_ack,
  output logic [CNT_W-1:0] rd_data,
  output logic             halted
);

  localparam int NUM_CNT = $bits(ovf);

  typedef enum logic [1:0] {
    IDLE,
    SNAP,
    ACK
  } rdState_t;

  typedef logic [NUM_CNT-1:0][CNT_W-1:0] cntArray_t;

  cntArray_t          cntQ;
  cntArray_t          cntNext;
  logic [NUM_CNT-1:0] ovfNext;
  logic               haltedNext;
  logic [NUM_CNT-1:0] incVec;
  logic               counting;

  cntArray_t          shadowQ;
  logic [NUM_CNT-1:0] shadowOvfQ;
  logic [CNT_W-1:0]   rdDataQ;

  rdState_t           stateQ;
  rdState_t           stateNext;

  // Readout mux shared by the SNAP register load and the live ACK path.
  function automatic logic [CNT_W-1:0] selectValue(
    input cntArray_t          cnts,
    input logic [NUM_CNT-1:0] flags,
    input logic [2:0]         sel
  );
    selectValue = '0;
    case (sel)
      3'd0: selectValue = cnts[0];
      3'd1: selectValue = cnts[1];
      3'd2: selectValue = cnts[2];
      3'd3: selectValue = cnts[3];
      3'd4: selectValue = cnts[4];
      3'd5: selectValue = cnts[5];
      3'd6: selectValue = CNT_W'(flags);
`ifdef PERF_STALL_CNT_EN
      3'd7: selectValue = cnts[6];
`endif
      default: selectValue = '0;
    endcase
  endfunction

  assign counting = cnt_en & ~halted;

  // Per-counter increment requests for this cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    incVec    = '0;
    incVec[0] = 1'b1;
    incVec[1] = halt | reg_wrt | mem_wrt;
    incVec[2] = dc_hit;
    incVec[3] = ic_hit;
    incVec[4] = dc_req;
    incVec[5] = ic_req;
`ifdef PERF_STALL_CNT_EN
    incVec[6] = stall;
`endif
  end

  // Next counter, overflow and halted state: clr wins over increments and halt.
  always_comb begin
    cntNext    = cntQ;
    ovfNext    = ovf;
    haltedNext = halted;
    if (clr) begin
      cntNext    = '0;
      ovfNext    = '0;
      haltedNext = 1'b0;
    end else if (counting) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (incVec[i]) begin
          if (&cntQ[i]) ovfNext[i] = 1'b1;
          else          cntNext[i] = cntQ[i] + 1'b1;
        end
      end
      if (halt) haltedNext = 1'b1;
    end
  end

  // Counter, overflow and halted registers.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the counter array is software-visible state, so unlike a plain
    // storage memory it is reset along with every other register.
    if (!rst) begin
      cntQ   <= '0;
      ovf    <= '0;
      halted <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      cntQ   <= cntNext;
      ovf    <= ovfNext;
      halted <= haltedNext;
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stateQ <= IDLE;
    else      stateQ <= stateNext;
  end

  // Read FSM next-state logic for the 4-phase handshake.
  always_comb begin
    stateNext = stateQ;
    case (stateQ)
      IDLE:    if (rd_req) stateNext = SNAP;
      SNAP:    stateNext = ACK;
      ACK:     if (!rd_req) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Snapshot capture: takes the values committed on this same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadowQ    <= '0;
      shadowOvfQ <= '0;
      rdDataQ    <= '0;
    end else if (stateQ == SNAP) begin
      shadowQ    <= cntNext;
      shadowOvfQ <= ovfNext;
      rdDataQ    <= selectValue(cntNext, ovfNext, rd_sel);
    end
  end

  assign rd_ack  = (stateQ == ACK);
  assign rd_data = (stateQ == ACK) ? selectValue(shadowQ, shadowOvfQ, rd_sel) : rdDataQ;

endmodule

// File: tb/tb_perf_counter_unit.sv
// Directed self-checking bench for perf_counter_unit, built with CNT_W=8 so
// saturation is reachable quickly. Honours PERF_STALL_CNT_EN if defined.
module tb_perf_counter_unit;

  localparam int CNT_W = 8;
`ifdef PERF_STALL_CNT_EN
  localparam int OVF_W = 7;
  localparam logic [31:0] SEL7_EXP = 32'd12;
`else
  localparam int OVF_W = 6;
  localparam logic [31:0] SEL7_EXP = 32'd0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cntEn = 1'b0, halt = 1'b0, regWrt = 1'b0, memWrt = 1'b0;
  logic dcReq = 1'b0, dcHit = 1'b0, icReq = 1'b0, icHit = 1'b0;
  logic clr = 1'b0, rdReq = 1'b0;
  logic [2:0] rdSel = 3'd0;
`ifdef PERF_STALL_CNT_EN
  logic stall = 1'b0;
`endif
  logic             rdAck;
  logic [CNT_W-1:0] rdData;
  logic             halted;
  logic [OVF_W-1:0] ovf;

  int testCount = 0;
  int failCount = 0;
  logic [CNT_W-1:0] val;

  perf_counter_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cnt_en(cntEn), .halt(halt), .reg_wrt(regWrt),
    .mem_wrt(memWrt), .dc_req(dcReq), .dc_hit(dcHit), .ic_req(icReq),
    .ic_hit(icHit), .clr(clr), .rd_req(rdReq), .rd_sel(rdSel),
`ifdef PERF_STALL_CNT_EN
    .stall(stall),
`endif
    .rd_ack(rdAck), .rd_data(rdData), .halted(halted), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) until rd_ack reaches lvl, sampling on falling edges.
  task automatic waitAck(input logic lvl, input string tag);
    int n = 0;
    while (rdAck !== lvl && n < 10) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(rdAck), 32'(lvl));
  endtask

  // Full 4-phase read of one selector.
  task automatic readSel(input logic [2:0] sel, output logic [CNT_W-1:0] v);
    rdSel = sel;
    rdReq = 1'b1;
    waitAck(1'b1, "ackRise");
    v = rdData;
    rdReq = 1'b0;
    waitAck(1'b0, "ackFall");
  endtask

  task automatic expectSel(input logic [2:0] sel, input logic [31:0] exp, input string tag);
    logic [CNT_W-1:0] v;
    readSel(sel, v);
    check(tag, 32'(v), exp);
  endtask

  task automatic pulseClr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    check("rstAck", 32'(rdAck), 0);
    check("rstData", 32'(rdData), 0);
    check("rstHalted", 32'(halted), 0);
    check("rstOvf", 32'(ovf), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Mixed stimulus over 20 cycles
    for (int c = 0; c < 20; c++) begin
      cntEn  = 1'b1;
      regWrt = (c < 5);
      memWrt = (c >= 4 && c <= 6);
      dcReq  = (c < 8);
      dcHit  = (c < 6);
      icReq  = (c >= 10 && c <= 12);
      icHit  = (c == 10 || c == 11);
      @(negedge clk);
    end
    {cntEn, regWrt, memWrt, dcReq, dcHit, icReq, icHit} = '0;
    expectSel(3'd0, 20, "mixCycles");
    expectSel(3'd1, 7, "mixInst");
    expectSel(3'd2, 6, "mixDcHit");
    expectSel(3'd3, 2, "mixIcHit");
    expectSel(3'd4, 8, "mixDcReq");
    expectSel(3'd5, 3, "mixIcReq");
    expectSel(3'd6, 0, "mixOvf");
    expectSel(3'd7, 0, "mixSel7");

    // Halt on the 15th counting cycle, then further activity is ignored
    pulseClr();
    for (int c = 0; c < 15; c++) begin
      cntEn = 1'b1;
      halt  = (c == 14);
      if (c == 14) check("haltedBefore", 32'(halted), 0);
      @(negedge clk);
    end
    halt = 1'b0;
    check("haltedSet", 32'(halted), 1);
    for (int c = 0; c < 50; c++) begin
      cntEn = 1'b1; regWrt = 1'b1; dcReq = 1'b1; dcHit = 1'b1; icReq = 1'b1;
      halt = (c == 20);
      @(negedge clk);
    end
    {cntEn, regWrt, dcReq, dcHit, icReq, halt} = '0;
    expectSel(3'd0, 15, "haltCycles");
    expectSel(3'd1, 1, "haltInst");
    expectSel(3'd4, 0, "haltDcReq");
    check("haltedHeld", 32'(halted), 1);

    // Async reset while in ACK
    rdSel = 3'd0;
    rdReq = 1'b1;
    waitAck(1'b1, "preRstAck");
    check("preRstData", 32'(rdData), 15);
    #3 rst = 1'b0;
    #1;
    check("asyncAck", 32'(rdAck), 0);
    check("asyncHalted", 32'(halted), 0);
    check("asyncOvf", 32'(ovf), 0);
    check("asyncData", 32'(rdData), 0);
    rdReq = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cntEn = 1'b1;
    repeat (10) @(negedge clk);
    cntEn = 1'b0;
    expectSel(3'd0, 10, "postRstCycles");
    expectSel(3'd1, 0, "postRstInst");

    // Handshake timing with counting running underneath
    cntEn = 1'b1; dcReq = 1'b1; rdSel = 3'd0; rdReq = 1'b1;
    @(negedge clk);
    check("hsAckEdge1", 32'(rdAck), 0);
    @(negedge clk);
    check("hsAckEdge2", 32'(rdAck), 1);
    check("hsSnap", 32'(rdData), 12);
    repeat (5) @(negedge clk);
    check("hsFrozen", 32'(rdData), 12);
    rdSel = 3'd4;
    #1;
    check("hsSel4", 32'(rdData), 2);
    rdReq = 1'b0; cntEn = 1'b0; dcReq = 1'b0;
    check("hsAckHold", 32'(rdAck), 1);
    @(negedge clk);
    check("hsAckDrop", 32'(rdAck), 0);
    expectSel(3'd0, 17, "hsCycles");
    expectSel(3'd4, 7, "hsDcReq");

    // clr leaves an active snapshot alone
    rdSel = 3'd0;
    rdReq = 1'b1;
    waitAck(1'b1, "clrAck");
    check("clrSnapBefore", 32'(rdData), 17);
    pulseClr();
    check("clrSnapKept", 32'(rdData), 17);
    check("clrAckKept", 32'(rdAck), 1);
    rdReq = 1'b0;
    waitAck(1'b0, "clrAckFall");

    // rd_req raised in the same cycle as clr
    clr = 1'b1; rdReq = 1'b1; rdSel = 3'd0;
    @(negedge clk);
    clr = 1'b0;
    waitAck(1'b1, "reqClrAck");
    check("reqClrSel0", 32'(rdData), 0);
    rdSel = 3'd4;
    #1;
    check("reqClrSel4", 32'(rdData), 0);
    rdReq = 1'b0;
    waitAck(1'b0, "reqClrFall");

    // Saturation at 8 bits
    cntEn = 1'b1; icReq = 1'b1;
    repeat (299) @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    {cntEn, icReq, halt} = '0;
    check("satHalted", 32'(halted), 1);
    check("satOvf", 32'(ovf), 32'h21);
    expectSel(3'd5, 255, "satIcReq");
    expectSel(3'd0, 255, "satCycles");
    expectSel(3'd1, 1, "satInst");
    expectSel(3'd6, 32'h21, "satOvfSel");
    pulseClr();
    check("clrOvf", 32'(ovf), 0);
    check("clrHalted", 32'(halted), 0);
    expectSel(3'd5, 0, "clrIcReq");
    expectSel(3'd6, 0, "clrOvfSel");

    // clr has priority over halt and increments in the same cycle
    cntEn = 1'b1; halt = 1'b1; regWrt = 1'b1; clr = 1'b1;
    @(negedge clk);
    {cntEn, halt, regWrt, clr} = '0;
    check("prioHalted", 32'(halted), 0);
    expectSel(3'd0, 0, "prioCycles");
    expectSel(3'd1, 0, "prioInst");

    // Stall counter (or zero on selector 7 without the feature)
    for (int c = 0; c < 30; c++) begin
      cntEn = 1'b1;
`ifdef PERF_STALL_CNT_EN
      stall = (c < 12);
`endif
      @(negedge clk);
    end
    cntEn = 1'b0;
`ifdef PERF_STALL_CNT_EN
    stall = 1'b0;
`endif
    expectSel(3'd0, 30, "stallCycles");
    expectSel(3'd7, SEL7_EXP, "stallSel7");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
